// File: rtl/fxp_pkg.sv
// fxp_pkg: Q8.8 fixed-point types, saturation helper and the FSM state
// encoding shared by the layer_backward slice.
package fxp_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;

    typedef logic signed [DATA_W-1:0]   fxp_t;
    typedef logic signed [2*DATA_W-1:0] fxp_prod_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELTA,
        S_GRAD,
        S_DONE
    } state_t;

    // Clamp a wide signed value into the Q8.8 range [0x8000, 0x7FFF].
    function automatic fxp_t sat16(input logic signed [63:0] v);
        if (v > 64'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -64'sd32768) begin
            return 16'sh8000;
        end else begin
            return fxp_t'(v[15:0]);
        end
    endfunction

endpackage

// File: rtl/fxp_mul_shift_sat.sv
// fxp_mul_shift_sat: signed Q8.8 multiply returning the raw 32-bit product
// and the rescaled (>>> FRAC_BITS), saturated 16-bit result.
import fxp_pkg::*;

module fxp_mul_shift_sat (
    input  fxp_t      a_i,
    input  fxp_t      b_i,
    output fxp_prod_t prod_o,
    output fxp_t      sat_o
);

    // Full-precision product, then arithmetic rescale and clamp.
    always_comb begin
        prod_o = fxp_prod_t'(a_i) * fxp_prod_t'(b_i);
        sat_o  = sat16(64'(prod_o >>> FRAC_BITS));
    end

endmodule

// File: rtl/layer_backward.sv
// layer_backward: backward pass of one fully-connected Q8.8 layer.
// Produces db, dw and dx from the upstream gradient dy.
// Build option: define LAYER_BWD_RELU_EN to mask delta with the ReLU derivative.
import fxp_pkg::*;

module layer_backward #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_IN*16-1:0]        x,
    input  logic [N_OUT*16-1:0]       y,
    input  logic [N_OUT*16-1:0]       dy,
    input  logic [N_OUT*N_IN*16-1:0]  w,
    output logic [N_IN*16-1:0]        dx,
    output logic [N_OUT*N_IN*16-1:0]  dw,
    output logic [N_OUT*16-1:0]       db,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W = 32 + $clog2(N_OUT + 1);
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;

    state_t                  state_q, state_d;
    logic [OW-1:0]           o_q;
    logic [IW-1:0]           i_q;
    logic                    o_last, i_last;
    logic                    drain_q;

    fxp_t                    x_q     [N_IN];
    fxp_t                    dy_q    [N_OUT];
    fxp_t                    w_q     [N_OUT][N_IN];
    fxp_t                    delta_q [N_OUT];
    fxp_t                    delta_new;
    logic signed [ACC_W-1:0] acc_q   [N_IN];
    logic signed [ACC_W-1:0] acc_d   [N_IN];

    logic                    pv_q;
    logic [OW-1:0]           po_q;
    logic [IW-1:0]           pi_q;
    fxp_prod_t               prod_q;
    fxp_t                    dwv_q;

    fxp_t                    dx_q [N_IN];
    fxp_t                    dw_q [N_OUT][N_IN];
    fxp_t                    db_q [N_OUT];

    fxp_prod_t               prod_dx;
    fxp_t                    sat_dw;
    fxp_prod_t               unused_prod_dw;
    fxp_t                    unused_sat_dx;

`ifdef LAYER_BWD_RELU_EN
    fxp_t                    y_q [N_OUT];
`else
    logic                    unused_y;
    assign unused_y = ^y;
`endif

    assign o_last = (o_q == OW'(N_OUT - 1));
    assign i_last = (i_q == IW'(N_IN - 1));

    fxp_mul_shift_sat u_mul_dw (
        .a_i    (delta_q[o_q]),
        .b_i    (x_q[i_q]),
        .prod_o (unused_prod_dw),
        .sat_o  (sat_dw)
    );

    fxp_mul_shift_sat u_mul_dx (
        .a_i    (w_q[o_q][i_q]),
        .b_i    (delta_q[o_q]),
        .prod_o (prod_dx),
        .sat_o  (unused_sat_dx)
    );

    // Masked (or pass-through) gradient for the output currently in DELTA.
    always_comb begin
`ifdef LAYER_BWD_RELU_EN
        delta_new = (y_q[o_q] > 16'sd0) ? dy_q[o_q] : '0;
`else
        delta_new = dy_q[o_q];
`endif
    end

    // Accumulators plus the product retired from the multiplier register this cycle.
    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            acc_d[i] = acc_q[i];
            if (pv_q && (pi_q == IW'(i))) begin
                acc_d[i] = acc_q[i] + ACC_W'(prod_q);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; GRAD holds one extra cycle to retire the last registered product.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)   state_d = S_DELTA;
            S_DELTA: if (o_last)  state_d = S_GRAD;
            S_GRAD:  if (drain_q) state_d = S_DONE;
            S_DONE:               state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath: operand capture, delta/db, pipelined gradient products, dx finalisation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q     <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
            pv_q    <= 1'b0;
            po_q    <= '0;
            pi_q    <= '0;
            prod_q  <= '0;
            dwv_q   <= '0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                x_q[i]   <= '0;
                acc_q[i] <= '0;
                dx_q[i]  <= '0;
            end
            for (int unsigned o = 0; o < N_OUT; o++) begin
                dy_q[o]    <= '0;
                delta_q[o] <= '0;
                db_q[o]    <= '0;
`ifdef LAYER_BWD_RELU_EN
                y_q[o]     <= '0;
`endif
                for (int unsigned i = 0; i < N_IN; i++) begin
                    w_q[o][i]  <= '0;
                    dw_q[o][i] <= '0;
                end
            end
        end else begin
            pv_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        o_q     <= '0;
                        i_q     <= '0;
                        drain_q <= 1'b0;
                        for (int unsigned i = 0; i < N_IN; i++) begin
                            x_q[i]   <= x[i*16 +: 16];
                            acc_q[i] <= '0;
                        end
                        for (int unsigned o = 0; o < N_OUT; o++) begin
                            dy_q[o] <= dy[o*16 +: 16];
`ifdef LAYER_BWD_RELU_EN
                            y_q[o]  <= y[o*16 +: 16];
`endif
                            for (int unsigned i = 0; i < N_IN; i++) begin
                                w_q[o][i] <= w[(o*N_IN + i)*16 +: 16];
                            end
                        end
                    end
                end
                S_DELTA: begin
                    delta_q[o_q] <= delta_new;
                    db_q[o_q]    <= delta_new;
                    o_q          <= o_last ? '0 : o_q + 1'b1;
                end
                S_GRAD: begin
                    if (!drain_q) begin
                        prod_q <= prod_dx;
                        dwv_q  <= sat_dw;
                        po_q   <= o_q;
                        pi_q   <= i_q;
                        pv_q   <= 1'b1;
                        if (i_last) begin
                            i_q <= '0;
                            if (o_last) begin
                                drain_q <= 1'b1;
                            end else begin
                                o_q <= o_q + 1'b1;
                            end
                        end else begin
                            i_q <= i_q + 1'b1;
                        end
                    end
                    if (pv_q) begin
                        dw_q[po_q][pi_q] <= dwv_q;
                    end
                    for (int unsigned i = 0; i < N_IN; i++) begin
                        acc_q[i] <= acc_d[i];
                        if (drain_q) begin
                            dx_q[i] <= sat16(64'(acc_d[i] >>> FRAC_BITS));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_dx
        assign dx[gi*16 +: 16] = dx_q[gi];
    end

    for (genvar go = 0; go < N_OUT; go++) begin : g_out
        assign db[go*16 +: 16] = db_q[go];
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_dw
            assign dw[(go*N_IN + gi)*16 +: 16] = dw_q[go][gi];
        end
    end

endmodule

// File: doc/layer_backward.md
# layer_backward

Backward-pass counterpart of the forward `layer` block. It takes the upstream gradient `dy` for one fully-connected layer and produces the bias gradient `db`, the weight gradient `dw`, and the input gradient `dx` for the preceding layer. It uses a single shared fixed-point multiplier, so it trades latency for area. Instances chain in reverse layer order inside the planned `network_backward`: `done` of layer i+1 drives `start` of layer i.

## Interface
Parameters:
- `N_IN`, default 2: number of layer inputs.
- `N_OUT`, default 1: number of layer outputs.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `x`  in  N_IN*16  forward-pass input activations, Q8.8 signed.
- `y`  in  N_OUT*16  forward-pass outputs, Q8.8 signed; used only for ReLU masking.
- `dy`  in  N_OUT*16  upstream gradient, Q8.8 signed.
- `w`  in  N_OUT*N_IN*16  weights, element (o,i) at index o*N_IN+i.
- `dx`  out  N_IN*16  input gradient, Q8.8 signed.
- `dw`  out  N_OUT*N_IN*16  weight gradient, same layout as `w`.
- `db`  out  N_OUT*16  bias gradient.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
States: IDLE → DELTA → GRAD → DONE → IDLE.
- **IDLE.** When `start`=1 at an edge, `x`, `y`, `dy` and `w` are captured into internal registers. At the same edge the `dx` accumulators are cleared and the FSM moves to DELTA. Inputs may change freely after that edge.
- **DELTA.** Runs N_OUT cycles, one per output o. Computes delta[o] = dy[o], or 0 when masked (see Configuration). Writes db[o] = delta[o].
- **GRAD.** Runs N_OUT*N_IN cycles. Order is o outer, i inner; the counters wrap i→0 and increment o at i=N_IN-1. Each cycle:
  - dw[o][i] = sat16((delta[o]*x[i]) >>> 8).
  - acc[i] += w[o][i]*delta[o], using the full 32-bit product.
- **DONE.** One cycle. For every i, dx[i] = sat16(acc[i] >>> 8). `done`=1. Return to IDLE.

Arithmetic rules:
- Products are 32-bit signed.
- Accumulators are 32+clog2(N_OUT+1) bits signed.
- `>>>` is arithmetic shift (truncation toward −inf).
- sat16 clamps to [0x8000, 0x7FFF].

Other behaviour:
- `start` is ignored outside IDLE.
- Outputs hold their last completed result until the next accepted start. They are undefined while `busy`=1.

## Timing
- Start accepted at edge k: `busy`=1 from k, `done`=1 in the cycle after edge k+N_OUT+N_OUT*N_IN+1. Total latency is N_OUT*(N_IN+1)+2 cycles.
- `start` held high through DONE is accepted again in the following IDLE cycle. Back-to-back runs therefore have 1 idle cycle between them.
- `start` coinciding with `rst_n`=0: reset wins, and the start is dropped.
- Reset values: `dx`, `dw` and `db` all 0; `busy`=0; `done`=0; FSM in IDLE; counters 0.
- Reset asserted mid-operation: the run is aborted and all of the above reset values hold at the next edge. There is no partial `done`.

## Configuration
- Macro `LAYER_BWD_RELU_EN`.
  - Defined: delta[o] = (y[o] > 0) ? dy[o] : 0. This is the ReLU derivative; y[o]=0 counts as masked.
  - Undefined: delta[o] = dy[o]. The `y` port exists but is unused.
- Latency is identical in both builds.

## Structure
- Shared package `fxp_pkg` holds:
  - `DATA_W`=16 and `FRAC_BITS`=8;
  - typedef `fxp_t` (signed [15:0]) and `fxp_prod_t` (signed [31:0]);
  - function `sat16`.
- Sub-module `fxp_mul_shift_sat` wraps the shared multiplier. It outputs both the raw 32-bit product (for accumulation) and the shifted, saturated 16-bit result (for `dw`).

## Test plan
Q8.8 encoding: 1.0 = 0x0100.
1. N_IN=2, N_OUT=1, x={1.0,2.0}, y=1.0, dy=0.5, w={0.25,−1.0} → db=0x0080, dw={0x0080,0x0100}, dx={0x0020,0xFF80}; `done` asserted exactly 4 cycles after the start edge.
2. Same stimulus as 1 but y=−0.5: with `LAYER_BWD_RELU_EN` → db, dw, dx all 0; without the macro → results identical to case 1.
3. x[0]=0x6400, dy=0x6400 → dw[0]=0x7FFF; with dy=0x9C00 → dw[0]=0x8000.
4. N_IN=1, N_OUT=3, w={1.0,2.0,−1.0}, dy={1.0,1.0,0.5}, y all positive → dx=0x0280 (accumulation across outputs).
5. Pulse `start` again 2 cycles into GRAD → ignored; exactly one `done`; results match a single run.
6. Drive `rst_n`=0 for one cycle mid-GRAD → next cycle `busy`=0, `done`=0, all outputs 0. A following start completes with correct results and nominal latency.
